rom_access_arbiter: RTL

- Shares the single boot ROM macro between two requesters: port 0 (instruction-side boot fetch) and port 1 (the AHB ROM slave wrapper).
- Replaces polling the ROM output with a fixed-latency access counter.
- Round-robin arbitration, address range and alignment checking, and a one-cycle completion pulse per requester.
- Sits between the requesters and the ROM pins (ROM_enable, ROM_OE, ROM_address, ROM_out).

---
 rtl/rom_access_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: two-port round-robin front end for the boot ROM.
// Fixed-latency reads, range/alignment checks, one-cycle ack per port.
module rom_access_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int ROM_BYTES = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              busy,
  output logic              ROM_enable,
  output logic              ROM_OE,
  output logic [ADDR_W-1:0] ROM_address,
  input  logic [DATA_W-1:0] ROM_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(READ_LAT - 1);
  localparam logic [ADDR_W:0] ROM_LIM = (ADDR_W + 1)'(ROM_BYTES);

  state_t            state;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              gnt_id;
  logic              pick;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_bad;

  // On contention the port that was not served last wins.
  always_comb begin
    pick      = req1 && (!req0 || !last_grant);
    pick_addr = pick ? addr1 : addr0;
    pick_bad  = ({1'b0, pick_addr} >= ROM_LIM) ||
                (pick_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= 1'b1;
      gnt_id      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      busy        <= 1'b0;
      ROM_enable  <= 1'b0;
      ROM_OE      <= 1'b0;
      ROM_address <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_id     <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            if (pick_bad) begin
              // No ROM cycle: report the error straight away.
              state <= DONE;
              ack0  <= !pick;
              ack1  <= pick;
              err0  <= !pick;
              err1  <= pick;
            end else begin
              state       <= ACCESS;
              cnt         <= '0;
              ROM_enable  <= 1'b1;
              ROM_OE      <= 1'b1;
              ROM_address <= pick_addr;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state       <= DONE;
            ROM_enable  <= 1'b0;
            ROM_OE      <= 1'b0;
            ROM_address <= '0;
            ack0        <= !gnt_id;
            ack1        <= gnt_id;
            rdata0      <= gnt_id ? '0 : ROM_out;
            rdata1      <= gnt_id ? ROM_out : '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
